// File: rtl/wmark_pkg.sv
// wmark_pkg: shared constants for the FIFO watermark block.
// Holds the register map, command codes, default read value, STATUS bit indices
// and the decoded command enum used by fifo_watermark and wmark_filter.
package wmark_pkg;

    localparam int unsigned REG_W  = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ADDR_W-1:0] REGADDR_STATUS    = 8'h00;
    localparam logic [ADDR_W-1:0] REGADDR_CTRL      = 8'h01;
    localparam logic [ADDR_W-1:0] REGADDR_CMD       = 8'h02;
    localparam logic [ADDR_W-1:0] REGADDR_THR_HIGH  = 8'h03;
    localparam logic [ADDR_W-1:0] REGADDR_THR_LOW   = 8'h04;
    localparam logic [ADDR_W-1:0] REGADDR_HOLD      = 8'h05;
    localparam logic [ADDR_W-1:0] REGADDR_PEAK_LAT  = 8'h06;
    localparam logic [ADDR_W-1:0] REGADDR_NHIGH_LAT = 8'h07;
    localparam logic [ADDR_W-1:0] REGADDR_LEVEL_LAT = 8'h08;
    localparam logic [ADDR_W-1:0] REGADDR_THR_SLOPE = 8'h09;
    localparam logic [ADDR_W-1:0] REGADDR_SLOPE     = 8'h0A;

    localparam logic [REG_W-1:0] CMD_RST = 16'h0000;
    localparam logic [REG_W-1:0] CMD_LAT = 16'h0001;
    localparam logic [REG_W-1:0] CMD_CLR = 16'h0002;

    localparam logic [REG_W-1:0] RD_DEFAULT = 16'hF001;

    localparam int unsigned STAT_LOW     = 0;
    localparam int unsigned STAT_HIGH    = 1;
    localparam int unsigned STAT_BELOW   = 2;
    localparam int unsigned STAT_ABOVE   = 3;
    localparam int unsigned STAT_CFG_ERR = 4;

    typedef enum logic [1:0] {
        CMDOP_NONE = 2'd0,
        CMDOP_RST  = 2'd1,
        CMDOP_LAT  = 2'd2,
        CMDOP_CLR  = 2'd3
    } cmd_op_e;

endpackage

// File: rtl/wmark_filter.sv
// wmark_filter: consecutive-cycle persistence filter for one comparison flag.
// Ports: clk_i/rst_i clock and async active-high reset, clr_i synchronous
// counter clear, flag_i registered comparison flag, hold_i persistence count,
// qual_c (combinational) flag has been 1 for more than hold_i cycles in a row.
module wmark_filter
    import wmark_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             flag_i,
    input  logic [CNT_W-1:0] hold_i,
    output logic             qual_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    // Counts previous consecutive cycles with the flag set, saturating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i || !flag_i) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Current flag included so HOLD=0 passes the flag straight through.
    assign qual_c = flag_i && (cnt_q >= hold_i);

endmodule

// File: rtl/fifo_watermark.sv
// fifo_watermark: FIFO occupancy watermark generator with hysteresis thresholds,
// persistence filtering, peak / high-crossing statistics and a 16-bit register bus.
// Ports: clk_i clock, rst_i async active-high reset, reg_we_i/reg_addr_i/reg_data_i
// register write, reg_data_o combinational read data, level_i FIFO fill level,
// watermark_high_o / watermark_low_o registered watermarks, cfg_err_o registered
// threshold-order error.
// Optional macro WMARK_RATE_EN adds a 256-cycle slope estimator (regs 0x09/0x0A)
// that can assert watermark_high_o early on a fast-rising level.
module fifo_watermark
    import wmark_pkg::*;
#(
    parameter int unsigned LW           = 12,
    parameter int unsigned THR_HIGH_DEF = 3072,
    parameter int unsigned THR_LOW_DEF  = 1024,
    parameter int unsigned HOLD_DEF     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_we_i,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic [REG_W-1:0]  reg_data_i,
    output logic [REG_W-1:0]  reg_data_o,
    input  logic [LW-1:0]     level_i,
    output logic              watermark_high_o,
    output logic              watermark_low_o,
    output logic              cfg_err_o
);

    logic              enable_q;
    logic [LW-1:0]     thr_high_q;
    logic [LW-1:0]     thr_low_q;
    logic [CNT_W-1:0]  hold_q;
    logic              above_q;
    logic              below_q;
    logic              cfg_err_q;
    logic              high_q;
    logic              low_q;
    logic [LW-1:0]     peak_q;
    logic [REG_W-1:0]  nhigh_q;
    logic [LW-1:0]     peak_lat_q;
    logic [REG_W-1:0]  nhigh_lat_q;
    logic [LW-1:0]     level_lat_q;

    cmd_op_e           cmd_op_c;
    logic              wr_ctrl_c;
    logic              wr_thr_high_c;
    logic              wr_thr_low_c;
    logic              wr_hold_c;
    logic              cmd_rst_c;
    logic              cmd_lat_c;
    logic              cmd_clr_c;
    logic              qual_hi_c;
    logic              qual_lo_c;
    logic              hi_cond_c;
    logic              high_d_c;
    logic              low_d_c;
    logic [REG_W-1:0]  status_c;

`ifdef WMARK_RATE_EN
    localparam logic [REG_W-1:0] THR_SLOPE_DEF = 16'h0100;
    localparam int unsigned      SLOPE_DIV_W   = 8;

    logic                   wr_thr_slope_c;
    logic [SLOPE_DIV_W-1:0] slope_div_q;
    logic [LW-1:0]          slope_ref_q;
    logic [REG_W-1:0]       slope_q;
    logic [REG_W-1:0]       thr_slope_q;
    logic                   early_c;
`endif

    // Register write and command decode.
    always_comb begin
        cmd_op_c      = CMDOP_NONE;
        wr_ctrl_c     = 1'b0;
        wr_thr_high_c = 1'b0;
        wr_thr_low_c  = 1'b0;
        wr_hold_c     = 1'b0;
`ifdef WMARK_RATE_EN
        wr_thr_slope_c = 1'b0;
`endif
        if (reg_we_i) begin
            case (reg_addr_i)
                REGADDR_CTRL:     wr_ctrl_c     = 1'b1;
                REGADDR_THR_HIGH: wr_thr_high_c = 1'b1;
                REGADDR_THR_LOW:  wr_thr_low_c  = 1'b1;
                REGADDR_HOLD:     wr_hold_c     = 1'b1;
`ifdef WMARK_RATE_EN
                REGADDR_THR_SLOPE: wr_thr_slope_c = 1'b1;
`endif
                REGADDR_CMD: begin
                    case (reg_data_i)
                        CMD_RST: cmd_op_c = CMDOP_RST;
                        CMD_LAT: cmd_op_c = CMDOP_LAT;
                        CMD_CLR: cmd_op_c = CMDOP_CLR;
                        default: cmd_op_c = CMDOP_NONE;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign cmd_rst_c = (cmd_op_c == CMDOP_RST);
    assign cmd_lat_c = (cmd_op_c == CMDOP_LAT);
    assign cmd_clr_c = (cmd_op_c == CMDOP_CLR);

    // Configuration registers; untouched by CMD RST.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q   <= 1'b0;
            thr_high_q <= LW'(THR_HIGH_DEF);
            thr_low_q  <= LW'(THR_LOW_DEF);
            hold_q     <= CNT_W'(HOLD_DEF);
        end else begin
            if (wr_ctrl_c)     enable_q   <= reg_data_i[0];
            if (wr_thr_high_c) thr_high_q <= reg_data_i[LW-1:0];
            if (wr_thr_low_c)  thr_low_q  <= reg_data_i[LW-1:0];
            if (wr_hold_c)     hold_q     <= reg_data_i[CNT_W-1:0];
        end
    end

    // Compare stage and threshold-order check, re-evaluated every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            above_q   <= 1'b0;
            below_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            above_q   <= (level_i >= thr_high_q);
            below_q   <= (level_i <= thr_low_q);
            cfg_err_q <= (thr_low_q >= thr_high_q);
        end
    end

    wmark_filter u_filt_hi (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cmd_rst_c),
        .flag_i (above_q),
        .hold_i (hold_q),
        .qual_c (qual_hi_c)
    );

    wmark_filter u_filt_lo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cmd_rst_c),
        .flag_i (below_q),
        .hold_i (hold_q),
        .qual_c (qual_lo_c)
    );

`ifdef WMARK_RATE_EN
    // Slope = level now minus level 256 cycles ago, refreshed every 256 cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slope_div_q <= '0;
            slope_ref_q <= '0;
            slope_q     <= '0;
            thr_slope_q <= THR_SLOPE_DEF;
        end else begin
            if (wr_thr_slope_c) thr_slope_q <= reg_data_i;
            slope_div_q <= slope_div_q + SLOPE_DIV_W'(1);
            if (slope_div_q == '1) begin
                slope_q     <= REG_W'(level_i) - REG_W'(slope_ref_q);
                slope_ref_q <= level_i;
            end
        end
    end

    assign early_c = ($signed(slope_q) > $signed(thr_slope_q)) && (level_i >= (thr_high_q >> 1));
`endif

    // cfg_err gating keeps high and low mutually exclusive.
    always_comb begin
        hi_cond_c = qual_hi_c;
`ifdef WMARK_RATE_EN
        hi_cond_c = qual_hi_c || early_c;
`endif
        high_d_c = hi_cond_c && enable_q && !cfg_err_q;
        low_d_c  = qual_lo_c && enable_q && !cfg_err_q;
    end

    // Watermark outputs and high-crossing counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            high_q  <= 1'b0;
            low_q   <= 1'b0;
            nhigh_q <= '0;
        end else if (cmd_rst_c) begin
            high_q  <= 1'b0;
            low_q   <= 1'b0;
            nhigh_q <= '0;
        end else begin
            high_q <= high_d_c;
            low_q  <= low_d_c;
            if (cmd_clr_c) begin
                nhigh_q <= '0;
            end else if (high_d_c && !high_q && (nhigh_q != '1)) begin
                nhigh_q <= nhigh_q + REG_W'(1);
            end
        end
    end

    // Peak tracker; a clear in the same cycle wins over a new maximum.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_q <= '0;
        end else if (cmd_rst_c || cmd_clr_c) begin
            peak_q <= '0;
        end else if (level_i > peak_q) begin
            peak_q <= level_i;
        end
    end

    // Snapshot registers captured by LAT, cleared by CLR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_lat_q  <= '0;
            nhigh_lat_q <= '0;
            level_lat_q <= '0;
        end else if (cmd_clr_c) begin
            peak_lat_q  <= '0;
            nhigh_lat_q <= '0;
            level_lat_q <= '0;
        end else if (cmd_lat_c) begin
            peak_lat_q  <= peak_q;
            nhigh_lat_q <= nhigh_q;
            level_lat_q <= level_i;
        end
    end

    always_comb begin
        status_c               = '0;
        status_c[STAT_LOW]     = low_q;
        status_c[STAT_HIGH]    = high_q;
        status_c[STAT_BELOW]   = below_q;
        status_c[STAT_ABOVE]   = above_q;
        status_c[STAT_CFG_ERR] = cfg_err_q;
    end

    // Combinational read decode.
    always_comb begin
        reg_data_o = RD_DEFAULT;
        case (reg_addr_i)
            REGADDR_STATUS:    reg_data_o = status_c;
            REGADDR_CTRL:      reg_data_o = REG_W'(enable_q);
            REGADDR_CMD:       reg_data_o = status_c;
            REGADDR_THR_HIGH:  reg_data_o = REG_W'(thr_high_q);
            REGADDR_THR_LOW:   reg_data_o = REG_W'(thr_low_q);
            REGADDR_HOLD:      reg_data_o = REG_W'(hold_q);
            REGADDR_PEAK_LAT:  reg_data_o = REG_W'(peak_lat_q);
            REGADDR_NHIGH_LAT: reg_data_o = nhigh_lat_q;
            REGADDR_LEVEL_LAT: reg_data_o = REG_W'(level_lat_q);
`ifdef WMARK_RATE_EN
            REGADDR_THR_SLOPE: reg_data_o = thr_slope_q;
            REGADDR_SLOPE:     reg_data_o = slope_q;
`endif
            default:           reg_data_o = RD_DEFAULT;
        endcase
    end

    assign watermark_high_o = high_q;
    assign watermark_low_o  = low_q;
    assign cfg_err_o        = cfg_err_q;

endmodule

// File: tb/tb_fifo_watermark.sv
// tb_fifo_watermark: self-checking bench for fifo_watermark.
// Register table vectors, hand sequences for the multi-cycle corners, and a
// randomized level stream checked against a run-length reference model.
`timescale 1ns/1ps
module tb_fifo_watermark;

    localparam int unsigned LW = 12;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          reg_we_i;
    logic [7:0]    reg_addr_i;
    logic [15:0]   reg_data_i;
    logic [15:0]   reg_data_o;
    logic [LW-1:0] level_i;
    logic          watermark_high_o;
    logic          watermark_low_o;
    logic          cfg_err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } wr_vec_t;

    fifo_watermark dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .reg_we_i         (reg_we_i),
        .reg_addr_i       (reg_addr_i),
        .reg_data_i       (reg_data_i),
        .reg_data_o       (reg_data_o),
        .level_i          (level_i),
        .watermark_high_o (watermark_high_o),
        .watermark_low_o  (watermark_low_o),
        .cfg_err_o        (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [15:0] d);
        reg_we_i   = 1'b1;
        reg_addr_i = a;
        reg_data_i = d;
        tick();
        reg_we_i   = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [7:0] a, input int exp);
        logic [15:0] d;
        reg_addr_i = a;
        #1;
        d = reg_data_o;
        check_val(name, 32'(d), exp);
    endtask

    task automatic hold_level(input int v, input int n);
        level_i = LW'(v);
        repeat (n) tick();
    endtask

    initial begin
        rd_vec_t rd_tab[$];
        wr_vec_t wr_tab[$];
        int      hv[3];
        int      bnd[6];

        rst_i      = 1'b1;
        reg_we_i   = 1'b0;
        reg_addr_i = 8'h00;
        reg_data_i = 16'h0000;
        level_i    = '0;
        hv         = '{0, 2, 5};
        bnd        = '{1023, 1024, 1025, 3071, 3072, 3073};

        // Reset defaults, read while reset is held so state stays frozen.
        rd_tab.push_back('{8'h00, 16'h0000});
        rd_tab.push_back('{8'h01, 16'h0000});
        rd_tab.push_back('{8'h02, 16'h0000});
        rd_tab.push_back('{8'h03, 16'h0C00});
        rd_tab.push_back('{8'h04, 16'h0400});
        rd_tab.push_back('{8'h05, 16'h0004});
        rd_tab.push_back('{8'h06, 16'h0000});
        rd_tab.push_back('{8'h07, 16'h0000});
        rd_tab.push_back('{8'h08, 16'h0000});
`ifdef WMARK_RATE_EN
        rd_tab.push_back('{8'h09, 16'h0100});
        rd_tab.push_back('{8'h0A, 16'h0000});
`else
        rd_tab.push_back('{8'h09, 16'hF001});
        rd_tab.push_back('{8'h0A, 16'hF001});
`endif
        rd_tab.push_back('{8'h20, 16'hF001});
        rd_tab.push_back('{8'hFF, 16'hF001});

        repeat (3) tick();
        check_bit("rst_high", watermark_high_o, 1'b0);
        check_bit("rst_low", watermark_low_o, 1'b0);
        check_bit("rst_cfg_err", cfg_err_o, 1'b0);
        foreach (rd_tab[i])
            check_reg($sformatf("rd_%02h", rd_tab[i].addr), rd_tab[i].addr, int'(rd_tab[i].exp));
        tick();
        rst_i = 1'b0;
        tick();

        // Write/readback table; the last entries restore the defaults.
        wr_tab.push_back('{8'h03, 16'hF123, 16'h0123});
        wr_tab.push_back('{8'h03, 16'h0C00, 16'h0C00});
        wr_tab.push_back('{8'h05, 16'hAB07, 16'h0007});
        wr_tab.push_back('{8'h05, 16'h0004, 16'h0004});
        wr_tab.push_back('{8'h01, 16'hFFFF, 16'h0001});
        wr_tab.push_back('{8'h01, 16'h0000, 16'h0000});
        wr_tab.push_back('{8'h00, 16'hFFFF, 16'h0004});
        foreach (wr_tab[i]) begin
            reg_wr(wr_tab[i].addr, wr_tab[i].wdata);
            check_reg($sformatf("wr_%02h_%04h", wr_tab[i].addr, wr_tab[i].wdata),
                      wr_tab[i].addr, int'(wr_tab[i].exp));
        end

        // Step 0 -> 3072 with HOLD=4: high after 6 cycles, low drops after 2.
        reg_wr(8'h01, 16'h0001);
        hold_level(0, 8);
        check_bit("pre_step_low", watermark_low_o, 1'b1);
        check_bit("pre_step_high", watermark_high_o, 1'b0);
        level_i = LW'(3072);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_bit($sformatf("step_high_c%0d", i), watermark_high_o, i >= 6);
            check_bit($sformatf("step_low_c%0d", i), watermark_low_o, i < 2);
        end

        // Enable drop and immediate re-enable while the condition holds.
        reg_wr(8'h01, 16'h0000);
        check_bit("dis_high_same", watermark_high_o, 1'b1);
        tick();
        check_bit("dis_high_next", watermark_high_o, 1'b0);
        reg_wr(8'h01, 16'h0001);
        check_bit("ren_high_same", watermark_high_o, 1'b0);
        tick();
        check_bit("ren_high_next", watermark_high_o, 1'b1);

        // Short pulse above threshold is filtered out.
        hold_level(2000, 3);
        reg_wr(8'h02, 16'h0002);
        level_i = LW'(3100);
        for (int i = 0; i < 11; i++) begin
            if (i == 3) level_i = LW'(2000);
            tick();
            check_bit($sformatf("pulse_high_c%0d", i), watermark_high_o, 1'b0);
        end
        reg_wr(8'h02, 16'h0001);
        check_reg("pulse_nhigh_lat", 8'h07, 0);

        // Threshold order error and recovery.
        hold_level(3100, 8);
        check_bit("cfg_pre_high", watermark_high_o, 1'b1);
        reg_wr(8'h04, 16'd3072);
        check_bit("cfg_err_wr", cfg_err_o, 1'b0);
        tick();
        check_bit("cfg_err_set", cfg_err_o, 1'b1);
        tick();
        check_bit("cfg_force_high", watermark_high_o, 1'b0);
        check_bit("cfg_force_low", watermark_low_o, 1'b0);
        repeat (3) tick();
        check_bit("cfg_hold_high", watermark_high_o, 1'b0);
        reg_wr(8'h04, 16'd1024);
        check_bit("cfg_err_still", cfg_err_o, 1'b1);
        tick();
        check_bit("cfg_err_clr", cfg_err_o, 1'b0);
        tick();
        check_bit("cfg_rec_high", watermark_high_o, 1'b1);

        // Ramp up and down, then latch and clear.
        hold_level(0, 3);
        reg_wr(8'h02, 16'h0002);
        for (int v = 0; v <= 4000; v += 250) hold_level(v, 1);
        hold_level(4000, 10);
        for (int v = 3750; v >= 500; v -= 250) hold_level(v, 1);
        hold_level(500, 2);
        reg_wr(8'h02, 16'h0001);
        check_reg("ramp_peak_lat", 8'h06, 4000);
        check_reg("ramp_nhigh_lat", 8'h07, 1);
        check_reg("ramp_level_lat", 8'h08, 500);
        reg_wr(8'h02, 16'h0002);
        reg_wr(8'h02, 16'h0001);
        check_reg("clr_peak_lat", 8'h06, 0);
        check_reg("clr_nhigh_lat", 8'h07, 0);
        check_reg("clr_level_lat", 8'h08, 500);

        // Asynchronous reset while high is asserted.
        reg_wr(8'h03, 16'd3000);
        check_reg("thr_high_3000", 8'h03, 3000);
        hold_level(3100, 10);
        check_bit("arst_pre_high", watermark_high_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check_bit("arst_high", watermark_high_o, 1'b0);
        check_bit("arst_low", watermark_low_o, 1'b0);
        tick();
        rst_i = 1'b0;
        tick();
        check_reg("arst_thr_high", 8'h03, 3072);
        check_reg("arst_ctrl", 8'h01, 0);

        // Randomized levels against a run-length model (thresholds 3072/1024).
        reg_wr(8'h01, 16'h0001);
        for (int b = 0; b < 3; b++) begin
            int   h;
            int   run_hi;
            int   run_lo;
            int   pk;
            int   nh;
            int   seg;
            int   lvl;
            logic exp_hi;
            logic exp_lo;
            logic prev_hi;

            h = hv[b];
            reg_wr(8'h05, 16'(h));
            hold_level(2000, 10);
            reg_wr(8'h02, 16'h0002);
            run_hi  = 0;
            run_lo  = 0;
            pk      = 0;
            nh      = 0;
            seg     = 0;
            lvl     = 2000;
            prev_hi = 1'b0;
            for (int c = 0; c < 250; c++) begin
                if (seg == 0) begin
                    case ($urandom_range(0, 3))
                        0:       lvl = int'($urandom_range(0, 1024));
                        1:       lvl = int'($urandom_range(1025, 3071));
                        2:       lvl = int'($urandom_range(3072, 4095));
                        default: lvl = bnd[$urandom_range(0, 5)];
                    endcase
                    seg = int'($urandom_range(1, h + 5));
                end
                seg--;
                level_i = LW'(lvl);
                exp_hi  = (run_hi >= h + 1);
                exp_lo  = (run_lo >= h + 1);
                tick();
                check_bit($sformatf("rand_h%0d_high_c%0d", h, c), watermark_high_o, exp_hi);
                check_bit($sformatf("rand_h%0d_low_c%0d", h, c), watermark_low_o, exp_lo);
                run_hi = (lvl >= 3072) ? run_hi + 1 : 0;
                run_lo = (lvl <= 1024) ? run_lo + 1 : 0;
                if (lvl > pk) pk = lvl;
                if (exp_hi && !prev_hi) nh++;
                prev_hi = exp_hi;
            end
            reg_wr(8'h02, 16'h0001);
            check_reg($sformatf("rand_h%0d_peak_lat", h), 8'h06, pk);
            check_reg($sformatf("rand_h%0d_nhigh_lat", h), 8'h07, nh);
            check_reg($sformatf("rand_h%0d_level_lat", h), 8'h08, lvl);
            check_bit($sformatf("rand_h%0d_cfg_err", h), cfg_err_o, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
